johnson_phase_monitor: RTL and testbench
========================================

Name: johnson_phase_monitor

Overview:
- Downstream consumer of the 8-phase distributor bus (8-bit Johnson sequence 0x00→0x01→0x03→…→0xFF→0xFE→…→0x80→0x00).
- Synchronises the bus into the clk domain and checks every step against the expected Johnson successor.
- Measures the step period and counts revolutions.
- Runs a lock FSM and reports sticky sequence and timeout errors to the supervisor.

Parameters:
- SYNC_STAGES, 2, synchroniser flops per phase bit (min 2).
- LOCK_STEPS, 16, consecutive valid steps required to enter LOCKED (1..255).
- TIMEOUT, 1023, idle clk cycles with no step before timeout (< 2^PERIOD_W-1).
- PERIOD_W, 16, width of the period counter and step_period.
- REV_W, 16, width of rev_count.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- phase_in  in  8  phase bus from the distributor; asynchronous to clk.
- clear_err  in  1  clears err_seq, err_timeout and err_count.
- locked  out  1  FSM in LOCKED.
- step_pulse  out  1  one-cycle pulse per detected change of the synchronised bus.
- rev_pulse  out  1  one-cycle pulse on a valid step into 0x00 while LOCKED.
- rev_count  out  REV_W  revolutions counted while LOCKED; wraps.
- step_period  out  PERIOD_W  clk cycles between the last two steps; saturating.
- period_valid  out  1  step_period is trustworthy (high only while LOCKED).
- err_seq  out  1  sticky: invalid step seen while LOCKED.
- err_timeout  out  1  sticky: no step for TIMEOUT cycles while in ACQUIRE or LOCKED.
- err_count  out  8  number of errors; saturates at 255.
- dir  out  1  direction of the last valid step (1 = reverse); constant 0 without the optional feature.

Behaviour:
- Reset (async):
  - All outputs 0; FSM = UNLOCKED.
  - Synchroniser chain, prev register, idle counter and good-step counter all 0.
- Synchroniser: each bit passes through SYNC_STAGES flops; s = last stage.
- Step detection:
  - prev loads s every cycle.
  - step = (s != prev); step_pulse = step, registered.
  - step_pulse rises exactly SYNC_STAGES+1 clk edges after a stable phase_in change.
- Successor rule: succ(x) = {x[6:0], ~x[7]}.
- Code validity: a code is valid iff it is one of the 16 Johnson states listed in Overview.
- Valid step: step AND prev valid AND s == succ(prev).
- Idle counter:
  - Cleared to 0 on step; otherwise increments, saturating at 2^PERIOD_W-1.
  - On step: step_period <= idle+1, saturated.
- FSM, UNLOCKED:
  - A step with s valid → ACQUIRE, good=0.
  - Nothing else is counted as an error.
- FSM, ACQUIRE:
  - Valid step → good+1; when good reaches LOCK_STEPS → LOCKED.
  - Invalid step → UNLOCKED; no error flagged.
  - Idle reaches TIMEOUT → UNLOCKED and err_timeout is set.
- FSM, LOCKED:
  - locked=1, period_valid=1.
  - Valid step with s==0x00 → rev_pulse=1 and rev_count+1 (wraps to 0 at 2^REV_W).
  - Invalid step → err_seq=1, err_count+1, → UNLOCKED.
  - Idle reaches TIMEOUT → err_timeout=1, err_count+1, → UNLOCKED.
- Output registers: locked, period_valid, rev_pulse and all error outputs are registered and update on the same edge as step_pulse.
- Leaving LOCKED: locked and period_valid fall on the same edge as the error is flagged; rev_count holds its value.
- clear_err: next edge clears err_seq, err_timeout and err_count.
- clear_err with a simultaneous error event: the error wins; the flag is set and err_count = 1.
- Simultaneous invalid step and TIMEOUT: impossible, because a step clears idle.
- Reset mid-operation: returns to the reset state immediately, regardless of FSM state.

Optional Feature:
- Macro: PHASE_MON_REVERSE_EN.
- Defined:
  - s == pred(prev), with pred(x) = {~x[0], x[7:1]}, is also a valid step; dir=1 for it, and dir=0 on a forward step.
  - A direction change while LOCKED is legal.
  - rev_pulse fires on any valid step into 0x00, in either direction.
- Not defined:
  - Predecessor steps are invalid; dir is constant 0.
  - No reverse logic is synthesised.

Test Plan:
- Reset then idle with phase_in=0x00 → all outputs 0, locked=0, no step_pulse.
- Drive the forward Johnson sequence, one step per 8 clk, for 40 steps:
  - step_pulse 3 clk after each change (SYNC_STAGES=2).
  - locked rises on the 16th valid step after the first step.
  - step_period=8, period_valid=1.
  - rev_pulse and rev_count increment at each 0x00.
- While LOCKED, jump from 0x07 to 0x3F → err_seq=1, err_count=1, locked=0 on the same edge; rev_count holds.
- While LOCKED, freeze phase_in for 1023 clk → err_timeout=1, err_count+1, locked=0.
- Assert clear_err on the same cycle as a new invalid step → err_seq=1, err_count=1.
- With PHASE_MON_REVERSE_EN, after lock reverse the sequence 0x03→0x01→0x00 → no error, dir=1, rev_pulse at 0x00.
- Without the macro, the same reverse stimulus → err_seq=1.

Source files
------------

// File: rtl/johnson_phase_monitor.sv
// johnson_phase_monitor: synchronises an 8-phase Johnson bus, checks each step, measures step period, counts revolutions
// Ports:
//   clk, reset      clock; asynchronous active-high reset
//   phase_in[7:0]   Johnson phase bus, asynchronous to clk
//   clear_err       clears err_seq, err_timeout and err_count (an error on the same edge still wins)
//   locked          lock FSM is in LOCKED
//   step_pulse      one-cycle pulse per change of the synchronised bus
//   rev_pulse       valid step into 0x00 while locked
//   rev_count       revolutions counted while locked, wraps
//   step_period     clk cycles between the last two steps, saturating
//   period_valid    step_period is trustworthy (high only while locked)
//   err_seq         sticky: invalid step while locked
//   err_timeout     sticky: no step for TIMEOUT cycles while acquiring or locked
//   err_count       errors flagged while locked, saturates at 255
//   dir             direction of the last valid step, 1 = reverse
// Define PHASE_MON_REVERSE_EN to also accept predecessor steps; without it dir is tied to 0.
module johnson_phase_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_STEPS  = 16,
  parameter int TIMEOUT     = 1023,
  parameter int PERIOD_W    = 16,
  parameter int REV_W       = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          phase_in,
  input  logic                clear_err,
  output logic                locked,
  output logic                step_pulse,
  output logic                rev_pulse,
  output logic [REV_W-1:0]    rev_count,
  output logic [PERIOD_W-1:0] step_period,
  output logic                period_valid,
  output logic                err_seq,
  output logic                err_timeout,
  output logic [7:0]          err_count,
  output logic                dir
);
  localparam logic [1:0] UNLOCKED = 2'd0;
  localparam logic [1:0] ACQUIRE  = 2'd1;
  localparam logic [1:0] LOCKED   = 2'd2;
  localparam logic [PERIOD_W-1:0] IDLE_MAX = '1;
  localparam logic [PERIOD_W-1:0] IDLE_TO  = PERIOD_W'(TIMEOUT);
  localparam logic [7:0] GOOD_LOCK = 8'(LOCK_STEPS);
  logic [SYNC_STAGES-1:0][7:0] sync;
  logic [7:0] s, prev, succ;
  logic [PERIOD_W-1:0] idle, idle_inc;
  logic [7:0] good, good_n;
  logic [1:0] state, state_n;
  logic step, fwd, bwd, valid, timeout, set_seq, set_to, rev_hit, inc;
  // Johnson codes are a run of ones anchored at bit 0 or at bit 7 (0x00 and 0xFF are both)
  function automatic logic johnson_ok(input logic [7:0] x);
    return ((x & (x + 8'd1)) == 8'd0) || ((~x & (~x + 8'd1)) == 8'd0);
  endfunction
  assign s        = sync[SYNC_STAGES-1];
  assign succ     = {prev[6:0], ~prev[7]};
  assign step     = s != prev;
  assign fwd      = step && johnson_ok(prev) && s == succ;
  assign valid    = fwd || bwd;
  assign timeout  = !step && idle == IDLE_TO;
  assign idle_inc = idle == IDLE_MAX ? idle : idle + 1'b1;
  assign inc      = state == LOCKED && (set_seq || set_to);
`ifdef PHASE_MON_REVERSE_EN
  logic [7:0] pred;
  assign pred = {~prev[0], prev[7:1]};
  assign bwd  = step && johnson_ok(prev) && s == pred;
  always_ff @(posedge clk or posedge reset)
    if (reset) dir <= 1'b0;
    else if (valid) dir <= bwd;
`else
  assign bwd = 1'b0;
  assign dir = 1'b0;
`endif
  always_comb begin
    state_n = state;
    good_n  = good;
    set_seq = 1'b0;
    set_to  = 1'b0;
    rev_hit = 1'b0;
    case (state)
      UNLOCKED: if (step && johnson_ok(s)) begin
        state_n = ACQUIRE;
        good_n  = '0;
      end
      ACQUIRE: if (valid) begin
        good_n  = good + 8'd1;
        state_n = good_n == GOOD_LOCK ? LOCKED : ACQUIRE;
      end else if (step || timeout) begin
        state_n = UNLOCKED;
        set_to  = timeout;
      end
      LOCKED: if (valid) rev_hit = s == 8'h00;
      else if (step || timeout) begin
        state_n = UNLOCKED;
        set_seq = step;
        set_to  = timeout;
      end
      default: state_n = UNLOCKED;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sync         <= '0;
      prev         <= '0;
      idle         <= '0;
      good         <= '0;
      state        <= UNLOCKED;
      step_pulse   <= 1'b0;
      step_period  <= '0;
      locked       <= 1'b0;
      period_valid <= 1'b0;
      rev_pulse    <= 1'b0;
      rev_count    <= '0;
      err_seq      <= 1'b0;
      err_timeout  <= 1'b0;
      err_count    <= '0;
    end else begin
      sync         <= {sync[SYNC_STAGES-2:0], phase_in};
      prev         <= s;
      step_pulse   <= step;
      idle         <= step ? '0 : idle_inc;
      if (step) step_period <= idle_inc;
      state        <= state_n;
      good         <= good_n;
      locked       <= state_n == LOCKED;
      period_valid <= state_n == LOCKED;
      rev_pulse    <= rev_hit;
      rev_count    <= rev_count + REV_W'(rev_hit);
      err_seq      <= set_seq || (err_seq && !clear_err);
      err_timeout  <= set_to || (err_timeout && !clear_err);
      err_count    <= clear_err ? {7'd0, inc} : err_count + 8'(inc && err_count != 8'hFF);
    end
endmodule

// File: tb/tb_johnson_phase_monitor.sv
// tb_johnson_phase_monitor: randomized bench comparing johnson_phase_monitor against an index-based reference model
module tb_johnson_phase_monitor;
  localparam int SYNC_STAGES = 2;
  localparam int LOCK_STEPS  = 16;
  localparam int TIMEOUT     = 1023;
  localparam int PERIOD_W    = 16;
  localparam int REV_W       = 16;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clear_err = 1'b0;
  logic [7:0] phase_in = 8'h00;
  logic locked, step_pulse, rev_pulse, period_valid, err_seq, err_timeout, dir;
  logic [REV_W-1:0] rev_count;
  logic [PERIOD_W-1:0] step_period;
  logic [7:0] err_count;
  johnson_phase_monitor #(
    .SYNC_STAGES(SYNC_STAGES), .LOCK_STEPS(LOCK_STEPS), .TIMEOUT(TIMEOUT),
    .PERIOD_W(PERIOD_W), .REV_W(REV_W)
  ) dut (
    .clk(clk), .reset(reset), .phase_in(phase_in), .clear_err(clear_err),
    .locked(locked), .step_pulse(step_pulse), .rev_pulse(rev_pulse),
    .rev_count(rev_count), .step_period(step_period), .period_valid(period_valid),
    .err_seq(err_seq), .err_timeout(err_timeout), .err_count(err_count), .dir(dir)
  );
  always #5 clk = ~clk;
  int vectors = 0;
  int miscompares = 0;
  logic [7:0] jtab [16];
  int cur_i = 0;
  logic [7:0] pipe [$];
  logic [7:0] m_s, m_prev;
  int m_idle, m_mode, m_good;
  logic e_sp, e_rp, e_locked, e_seq, e_to, e_dir;
  int e_rev, e_per, e_cnt;
  int rev_before, r, gap, ix;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int idx_of(input logic [7:0] x);
    for (int i = 0; i < 16; i++) if (jtab[i] == x) return i;
    return -1;
  endfunction
  task automatic model_reset();
    pipe.delete();
    repeat (SYNC_STAGES - 1) pipe.push_back(8'h00);
    m_s = 0; m_prev = 0; m_idle = 0; m_mode = 0; m_good = 0;
    e_sp = 0; e_rp = 0; e_locked = 0; e_seq = 0; e_to = 0; e_dir = 0;
    e_rev = 0; e_per = 0; e_cnt = 0;
  endtask
  // mode 0 = unlocked, 1 = acquiring, 2 = locked; steps judged by position in the 16-entry ring
  task automatic model_edge();
    int ip, is;
    bit st, fw, rv, vs, to, s_seq, s_to, inc;
    if (reset) begin
      model_reset();
      return;
    end
    st = m_s != m_prev;
    ip = idx_of(m_prev);
    is = idx_of(m_s);
    fw = st && ip >= 0 && is == (ip + 1) % 16;
    rv = 0;
`ifdef PHASE_MON_REVERSE_EN
    rv = st && ip >= 0 && is == (ip + 15) % 16;
`endif
    vs = fw || rv;
    to = !st && m_idle == TIMEOUT;
    s_seq = 0; s_to = 0; inc = 0;
    e_sp = st;
    e_rp = 0;
    if (vs) e_dir = rv;
    if (m_mode == 0) begin
      if (st && is >= 0) begin m_mode = 1; m_good = 0; end
    end else if (m_mode == 1) begin
      if (vs) begin
        m_good++;
        if (m_good == LOCK_STEPS) m_mode = 2;
      end else if (st) m_mode = 0;
      else if (to) begin m_mode = 0; s_to = 1; end
    end else begin
      if (vs) begin
        if (m_s == 8'h00) begin e_rp = 1; e_rev = (e_rev + 1) % (1 << REV_W); end
      end else if (st) begin m_mode = 0; s_seq = 1; inc = 1; end
      else if (to) begin m_mode = 0; s_to = 1; inc = 1; end
    end
    if (clear_err) begin
      e_seq = s_seq; e_to = s_to; e_cnt = inc;
    end else begin
      e_seq = e_seq | s_seq; e_to = e_to | s_to;
      e_cnt = (e_cnt + inc > 255) ? 255 : e_cnt + inc;
    end
    if (st) begin
      e_per = (m_idle + 1 > (1 << PERIOD_W) - 1) ? (1 << PERIOD_W) - 1 : m_idle + 1;
      m_idle = 0;
    end else m_idle = (m_idle + 1 > (1 << PERIOD_W) - 1) ? (1 << PERIOD_W) - 1 : m_idle + 1;
    e_locked = m_mode == 2;
    m_prev = m_s;
    pipe.push_back(phase_in);
    m_s = pipe.pop_front();
  endtask
  task automatic check_all();
    check("step_pulse", 32'(step_pulse), 32'(e_sp));
    check("rev_pulse", 32'(rev_pulse), 32'(e_rp));
    check("locked", 32'(locked), 32'(e_locked));
    check("period_valid", 32'(period_valid), 32'(e_locked));
    check("rev_count", 32'(rev_count), 32'(e_rev));
    check("step_period", 32'(step_period), 32'(e_per));
    check("err_seq", 32'(err_seq), 32'(e_seq));
    check("err_timeout", 32'(err_timeout), 32'(e_to));
    check("err_count", 32'(err_count), 32'(e_cnt));
    check("dir", 32'(dir), 32'(e_dir));
  endtask
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask
  task automatic hold(input int n);
    repeat (n) tick();
  endtask
  task automatic go(input logic [7:0] code, input int n);
    phase_in = code;
    hold(n);
  endtask
  task automatic fwd_steps(input int n, input int g);
    repeat (n) begin
      cur_i = (cur_i + 1) % 16;
      go(jtab[cur_i], g);
    end
  endtask
  initial begin
    for (int i = 0; i < 16; i++)
      jtab[i] = i <= 8 ? 8'((1 << i) - 1) : 8'((255 << (i - 8)) & 255);
    model_reset();
    reset = 1'b1;
    hold(3);
    reset = 1'b0;
    hold(20);
    check("idle_locked", 32'(locked), 0);
    check("idle_step_pulse", 32'(step_pulse), 0);
    check("idle_err_count", 32'(err_count), 0);
    cur_i = 1;
    phase_in = jtab[1];
    tick();
    tick();
    check("latency_early", 32'(step_pulse), 0);
    tick();
    check("latency_edge3", 32'(step_pulse), 1);
    hold(5);
    fwd_steps(39, 8);
    check("fwd_locked", 32'(locked), 1);
    check("fwd_period_valid", 32'(period_valid), 1);
    check("fwd_period", 32'(step_period), 8);
    check("fwd_rev_count", 32'(rev_count), 1);
    while (cur_i != 3) fwd_steps(1, 8);
    go(8'h3F, 8);
    check("jump_err_seq", 32'(err_seq), 1);
    check("jump_err_count", 32'(err_count), 1);
    check("jump_locked", 32'(locked), 0);
    check("jump_rev_hold", 32'(rev_count), 2);
    cur_i = 6;
    fwd_steps(20, 8);
    check("relock", 32'(locked), 1);
    hold(1100);
    check("freeze_err_timeout", 32'(err_timeout), 1);
    check("freeze_err_count", 32'(err_count), 2);
    check("freeze_locked", 32'(locked), 0);
    fwd_steps(20, 8);
    cur_i = (cur_i + 5) % 16;
    phase_in = jtab[cur_i];
    tick();
    tick();
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    check("clr_race_err_seq", 32'(err_seq), 1);
    check("clr_race_err_count", 32'(err_count), 1);
    check("clr_race_err_timeout", 32'(err_timeout), 0);
    hold(5);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    check("clear_err_count", 32'(err_count), 0);
    fwd_steps(20, 8);
    while (cur_i != 2) fwd_steps(1, 8);
    check("rev_pre_locked", 32'(locked), 1);
    rev_before = e_rev;
    go(8'h01, 8);
    go(8'h00, 8);
    cur_i = 0;
`ifdef PHASE_MON_REVERSE_EN
    check("reverse_err_seq", 32'(err_seq), 0);
    check("reverse_dir", 32'(dir), 1);
    check("reverse_locked", 32'(locked), 1);
    check("reverse_rev_count", 32'(rev_count), 32'((rev_before + 1) % (1 << REV_W)));
`else
    check("reverse_err_seq", 32'(err_seq), 1);
    check("reverse_dir", 32'(dir), 0);
    check("reverse_rev_hold", 32'(rev_count), 32'(rev_before));
`endif
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      gap = $urandom_range(1, 12);
      if (r < 74) begin
        cur_i = (cur_i + 1) % 16;
        go(jtab[cur_i], gap);
      end else if (r < 82) begin
        cur_i = (cur_i + 15) % 16;
        go(jtab[cur_i], gap);
      end else if (r < 89) begin
        phase_in = 8'($urandom_range(0, 255));
        ix = idx_of(phase_in);
        if (ix >= 0) cur_i = ix;
        hold(gap);
      end else if (r < 92) hold($urandom_range(1030, 1060));
      else if (r < 97) begin
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        hold(gap);
      end else begin
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        check("async_reset_locked", 32'(locked), 0);
        hold(2);
        reset = 1'b0;
        hold(gap);
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
